// File: rtl/rice_core_fetch_unit.sv
// In-order instruction fetch: credit-limited bus requests, response FIFO and a stall/flush-aware
// output register feeding decode. Define RICE_CORE_FETCH_ASSERTION_EN to compile in protocol assertions.
module rice_core_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] INIT_PC    = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    input  logic            i_stall,
    output logic            o_request_valid,
    input  logic            i_request_ready,
    output logic [XLEN-1:0] o_request_address,
    input  logic            i_response_valid,
    input  logic [31:0]     i_response_data,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_pc,
    output logic [31:0]     o_if_inst
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int DISC_W = CNT_W + 8;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [DISC_W-1:0] discard_q, discard_d;

    logic [PTR_W-1:0]  pcq_wr_q, pcq_wr_d;
    logic [PTR_W-1:0]  pcq_rd_q, pcq_rd_d;
    logic [XLEN-1:0]   pcq_mem_q [FIFO_DEPTH];
    logic [XLEN-1:0]   pcq_mem_d [FIFO_DEPTH];

    logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [XLEN-1:0]   fifo_pc_q [FIFO_DEPTH];
    logic [XLEN-1:0]   fifo_pc_d [FIFO_DEPTH];
    logic [31:0]       fifo_inst_q [FIFO_DEPTH];
    logic [31:0]       fifo_inst_d [FIFO_DEPTH];

    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [31:0]       if_inst_q, if_inst_d;

    logic [CNT_W:0]    credit_used;
    logic [XLEN-1:0]   pcq_head;
    logic              req_fire;
    logic              resp_pair;
    logic              resp_drop;
    logic              load_en;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              bypass;
    logic              fifo_push;

    // Credit covers both in-flight requests and buffered words, so the FIFO can never overflow.
    always_comb begin
        credit_used       = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
        o_request_valid   = i_enable && !i_flush && (credit_used < DEPTH_C);
        o_request_address = pc_q;
        req_fire          = o_request_valid && i_request_ready;
        pcq_head          = pcq_mem_q[pcq_rd_q];
        resp_drop         = i_response_valid &&
                            ((discard_q != '0) || (i_flush && (outstanding_q != '0)));
        resp_pair         = i_response_valid && !i_flush &&
                            (discard_q == '0) && (outstanding_q != '0);
        fifo_empty        = (fifo_cnt_q == '0);
        load_en           = !i_flush && i_enable && !i_stall;
        fifo_pop          = load_en && !fifo_empty;
        bypass            = load_en && fifo_empty && resp_pair;
        fifo_push         = resp_pair && !bypass;
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;
        pcq_mem_d     = pcq_mem_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_inst_d   = fifo_inst_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;

        if (i_flush) begin
            // Everything still on the bus becomes a discard; a response dropped now is already gone.
            pc_d          = i_flush_pc & ~XLEN'(3);
            discard_d     = discard_q + DISC_W'(outstanding_q) - DISC_W'(resp_drop);
            outstanding_d = '0;
            pcq_wr_d      = '0;
            pcq_rd_d      = '0;
            fifo_wr_d     = '0;
            fifo_rd_d     = '0;
            fifo_cnt_d    = '0;
            if_valid_d    = 1'b0;
        end else begin
            if (req_fire) begin
                pc_d                = pc_q + XLEN'(4);
                pcq_mem_d[pcq_wr_q] = pc_q;
                pcq_wr_d            = pcq_wr_q + PTR_W'(1);
            end
            if (resp_drop) begin
                discard_d = discard_q - DISC_W'(1);
            end
            if (resp_pair) begin
                pcq_rd_d = pcq_rd_q + PTR_W'(1);
            end
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_pair);

            if (fifo_push) begin
                fifo_pc_d[fifo_wr_q]   = pcq_head;
                fifo_inst_d[fifo_wr_q] = i_response_data;
                fifo_wr_d              = fifo_wr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                fifo_rd_d = fifo_rd_q + PTR_W'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

            // Buffered words are older than any response arriving now, so they go out first.
            if (!i_enable) begin
                if_valid_d = 1'b0;
            end else if (!i_stall) begin
                if (!fifo_empty) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = fifo_pc_q[fifo_rd_q];
                    if_inst_d  = fifo_inst_q[fifo_rd_q];
                end else if (resp_pair) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pcq_head;
                    if_inst_d  = i_response_data;
                end else begin
                    if_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q          <= INIT_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_inst_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
        end
    end

    // Storage arrays carry no reset; their occupancy is tracked by the pointers above.
    always_ff @(posedge i_clk) begin
        pcq_mem_q   <= pcq_mem_d;
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
    end

    assign o_if_valid = if_valid_q;
    assign o_if_pc    = if_pc_q;
    assign o_if_inst  = if_inst_q;

`ifdef RICE_CORE_FETCH_ASSERTION_EN
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_response_valid && (outstanding_q == '0) && (discard_q == '0)))
                else $error("fetch: response with nothing in flight");
            assert (!(fifo_push && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))))
                else $error("fetch: push into full instruction FIFO");
            assert (o_request_address[1:0] == 2'b00)
                else $error("fetch: misaligned request address");
            if (i_stall && i_enable && !i_flush) begin
                assert ((if_valid_d == if_valid_q) && (if_pc_d == if_pc_q) && (if_inst_d == if_inst_q))
                    else $error("fetch: output register changed while stalled");
            end
        end
    end
`endif

endmodule

// File: tb/tb_rice_core_fetch_unit.sv
// Bench for rice_core_fetch_unit: directed scenarios then randomized traffic against a queue-based model.
module tb_rice_core_fetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_enable = 1'b0;
    logic            i_flush = 1'b0;
    logic [XLEN-1:0] i_flush_pc = '0;
    logic            i_stall = 1'b0;
    logic            o_request_valid;
    logic            i_request_ready = 1'b0;
    logic [XLEN-1:0] o_request_address;
    logic            i_response_valid = 1'b0;
    logic [31:0]     i_response_data = '0;
    logic            o_if_valid;
    logic [XLEN-1:0] o_if_pc;
    logic [31:0]     o_if_inst;

    always #5 i_clk = ~i_clk;

    rice_core_fetch_unit #(.XLEN(XLEN), .INIT_PC('0), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_enable          (i_enable),
        .i_flush           (i_flush),
        .i_flush_pc        (i_flush_pc),
        .i_stall           (i_stall),
        .o_request_valid   (o_request_valid),
        .i_request_ready   (i_request_ready),
        .o_request_address (o_request_address),
        .i_response_valid  (i_response_valid),
        .i_response_data   (i_response_data),
        .o_if_valid        (o_if_valid),
        .o_if_pc           (o_if_pc),
        .o_if_inst         (o_if_inst)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Bus environment: accepted addresses return in order, word = address.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_t;
    bus_t bus_q[$];
    int   lat_min = 0;
    int   lat_max = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_inflight[$];
    int          m_discard;
    logic [31:0] m_buf_pc[$];
    logic [31:0] m_buf_inst[$];
    logic        m_valid;
    logic [31:0] m_opc;
    logic [31:0] m_oinst;
    logic        m_loaded;
    logic [31:0] seq_pc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_inflight.delete();
        m_discard = 0;
        m_buf_pc.delete();
        m_buf_inst.delete();
        m_valid = 1'b0;
        m_opc = '0;
        m_oinst = '0;
        m_loaded = 1'b0;
        seq_pc = '0;
    endtask

    task automatic step();
        logic        m_req;
        logic        fire_act;
        logic [31:0] addr_act;
        logic        paired;
        logic [31:0] ppc;
        bus_t        e;
        i_response_valid = 1'b0;
        i_response_data  = '0;
        if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
            i_response_valid = 1'b1;
            i_response_data  = bus_q[0].addr;
            bus_q.delete(0);
        end
        #1;
        m_req = i_enable && !i_flush && ((m_inflight.size() + m_buf_pc.size()) < DEPTH);
        chk("req_valid", {63'd0, o_request_valid}, {63'd0, m_req});
        chk("req_addr", {32'd0, o_request_address}, {32'd0, m_pc});
        fire_act = o_request_valid && i_request_ready;
        addr_act = o_request_address;
        @(posedge i_clk);
        if (fire_act) begin
            e.addr = addr_act;
            e.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
            bus_q.push_back(e);
        end
        m_loaded = 1'b0;
        paired   = 1'b0;
        ppc      = '0;
        if (i_response_valid) begin
            if (m_discard > 0) begin
                m_discard--;
            end else if (m_inflight.size() > 0) begin
                ppc    = m_inflight.pop_front();
                paired = !i_flush;
            end
        end
        if (i_flush) begin
            m_discard += m_inflight.size();
            m_inflight.delete();
            m_buf_pc.delete();
            m_buf_inst.delete();
            m_valid = 1'b0;
            m_pc    = {i_flush_pc[31:2], 2'b00};
            seq_pc  = m_pc;
        end else begin
            if (m_req && i_request_ready) begin
                m_inflight.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (!i_enable || i_stall) begin
                if (!i_enable) m_valid = 1'b0;
                if (paired) begin
                    m_buf_pc.push_back(ppc);
                    m_buf_inst.push_back(i_response_data);
                end
            end else if (m_buf_pc.size() > 0) begin
                m_valid  = 1'b1;
                m_opc    = m_buf_pc.pop_front();
                m_oinst  = m_buf_inst.pop_front();
                m_loaded = 1'b1;
                if (paired) begin
                    m_buf_pc.push_back(ppc);
                    m_buf_inst.push_back(i_response_data);
                end
            end else if (paired) begin
                m_valid  = 1'b1;
                m_opc    = ppc;
                m_oinst  = i_response_data;
                m_loaded = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        cyc++;
        #1;
        chk("if_valid", {63'd0, o_if_valid}, {63'd0, m_valid});
        if (m_valid) begin
            chk("if_pc", {32'd0, o_if_pc}, {32'd0, m_opc});
            chk("if_inst", {32'd0, o_if_inst}, {32'd0, m_oinst});
        end
        if (m_loaded) begin
            chk("seq_pc", {32'd0, o_if_pc}, {32'd0, seq_pc});
            seq_pc = seq_pc + 32'd4;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic [31:0] held_addr;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", {63'd0, o_if_valid}, 64'd0);
        chk("rst_pc", {32'd0, o_if_pc}, 64'd0);
        chk("rst_inst", {32'd0, o_if_inst}, 64'd0);
        chk("rst_addr", {32'd0, o_request_address}, 64'd0);

        // Zero-wait streaming: first result two cycles after first accept
        i_rst_n = 1'b1;
        i_enable = 1'b1;
        i_request_ready = 1'b1;
        lat_min = 0;
        lat_max = 0;
        step();
        chk("lat_c1_valid", {63'd0, o_if_valid}, 64'd0);
        chk("lat_c1_addr", {32'd0, o_request_address}, 64'h4);
        step();
        chk("lat_c2_valid", {63'd0, o_if_valid}, 64'd1);
        chk("lat_c2_pc", {32'd0, o_if_pc}, 64'h0);
        chk("lat_c2_inst", {32'd0, o_if_inst}, 64'h0);
        chk("lat_c2_addr", {32'd0, o_request_address}, 64'h8);
        step();
        chk("lat_c3_pc", {32'd0, o_if_pc}, 64'h4);
        repeat (4) step();

        // Stall for three cycles
        held_pc = o_if_pc;
        held_inst = o_if_inst;
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold_valid", {63'd0, o_if_valid}, 64'd1);
            chk("stall_hold_pc", {32'd0, o_if_pc}, {32'd0, held_pc});
            chk("stall_hold_inst", {32'd0, o_if_inst}, {32'd0, held_inst});
        end
        chk("stall_credit", {63'd0, o_request_valid}, 64'd0);
        i_stall = 1'b0;
        repeat (6) step();

        // Flush with two requests in flight
        lat_min = 2;
        lat_max = 2;
        for (int k = 0; k < 10 && m_inflight.size() != 2; k++) step();
        i_flush = 1'b1;
        i_flush_pc = 32'h103;
        step();
        i_flush = 1'b0;
        lat_min = 0;
        lat_max = 0;
        chk("flush_addr", {32'd0, o_request_address}, 64'h100);
        for (int k = 0; k < 12 && !o_if_valid; k++) step();
        chk("flush_first_valid", {63'd0, o_if_valid}, 64'd1);
        chk("flush_first_pc", {32'd0, o_if_pc}, 64'h100);
        repeat (3) step();

        // Bus not ready for four cycles
        i_request_ready = 1'b0;
        held_addr = o_request_address;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rdy_hold_addr", {32'd0, o_request_address}, {32'd0, held_addr});
        end
        chk("rdy_no_result", {63'd0, o_if_valid}, 64'd0);
        i_request_ready = 1'b1;
        repeat (5) step();

        // Enable low for two cycles with a response in flight
        lat_min = 1;
        lat_max = 1;
        repeat (3) step();
        i_enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("en_low_valid", {63'd0, o_if_valid}, 64'd0);
        end
        i_enable = 1'b1;
        repeat (6) step();

        // Asynchronous reset with two requests outstanding
        lat_min = 2;
        lat_max = 2;
        for (int k = 0; k < 10 && m_inflight.size() != 2; k++) step();
        i_rst_n = 1'b0;
        #1;
        chk("mrst_valid", {63'd0, o_if_valid}, 64'd0);
        chk("mrst_pc", {32'd0, o_if_pc}, 64'd0);
        chk("mrst_inst", {32'd0, o_if_inst}, 64'd0);
        chk("mrst_addr", {32'd0, o_request_address}, 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_response_valid = 1'b0;
        bus_q.delete();
        model_reset();
        cyc++;
        lat_min = 0;
        lat_max = 0;
        step();
        chk("mrst_next_addr", {32'd0, o_request_address}, 64'h4);
        repeat (4) step();

        // Randomized traffic
        lat_min = 0;
        lat_max = 3;
        for (int k = 0; k < 1500; k++) begin
            i_enable        = ($urandom_range(7, 0) != 0);
            i_stall         = i_enable && ($urandom_range(3, 0) == 0);
            i_request_ready = ($urandom_range(3, 0) != 0);
            i_flush         = ($urandom_range(39, 0) == 0);
            i_flush_pc      = $urandom;
            step();
        end
        i_flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
